// File: rtl/video_timing_reader_if.sv
// Frame-buffer read bus between the video timing reader and the read DMA/FIFO.
// The reader is the master: it requests frames and strobes pixel reads.
interface video_timing_reader_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  read_req;
    logic                  read_req_ack;
    logic                  read_en;
    logic                  read_empty;
    logic [DATA_WIDTH-1:0] read_data;

    modport master (
        output read_req,
        output read_en,
        input  read_req_ack,
        input  read_empty,
        input  read_data
    );

    modport slave (
        input  read_req,
        input  read_en,
        output read_req_ack,
        output read_empty,
        output read_data
    );
endinterface

// File: rtl/video_timing_reader.sv
// Programmable raster generator that fetches one frame per frame from the read DMA
// and emits pixel-aligned hs/vs/de/data; unfed pixels become bg_color. READ_LATENCY: 1..4.
module video_timing_reader #(
    parameter int DATA_WIDTH   = 16,
    parameter int H_ACTIVE     = 1280,
    parameter int H_FP         = 110,
    parameter int H_SYNC       = 40,
    parameter int H_BP         = 220,
    parameter int V_ACTIVE     = 720,
    parameter int V_FP         = 5,
    parameter int V_SYNC       = 5,
    parameter int V_BP         = 20,
    parameter int HS_POL       = 1,
    parameter int VS_POL       = 1,
    parameter int READ_LATENCY = 1
) (
    input  logic                  video_clk,
    input  logic                  rst,
    input  logic                  enable,
    video_timing_reader_if.master rd,
    input  logic [DATA_WIDTH-1:0] bg_color,
    output logic                  hs,
    output logic                  vs,
    output logic                  de,
    output logic [DATA_WIDTH-1:0] vout_data,
    output logic                  frame_start,
    output logic                  underflow,
    output logic                  req_miss
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    typedef enum logic [1:0] {IDLE, REQ, ARMED, STREAM} state_t;

    typedef struct packed {
        logic fs;
        logic hs;
        logic vs;
        logic de;
        logic tag;
    } timing_t;

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           h_last;
    logic           v_last;
    logic           de_raw;
    logic           hs_raw;
    logic           vs_raw;
    logic           fs;
    logic           vblank_start;
    logic           stream_now;
    state_t         state_q;
    state_t         state_d;
    timing_t        raw;
    timing_t        dly [READ_LATENCY];
    timing_t        tap;

    assign h_last = (h_cnt == H_W'(H_TOTAL - 1));
    assign v_last = (v_cnt == V_W'(V_TOTAL - 1));

    // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge video_clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + V_W'(1);
        end else begin
            h_cnt <= h_cnt + H_W'(1);
        end
    end

    assign de_raw       = (h_cnt < H_W'(H_ACTIVE)) && (v_cnt < V_W'(V_ACTIVE));
    assign hs_raw       = (h_cnt >= H_W'(H_ACTIVE + H_FP)) &&
                          (h_cnt <  H_W'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_raw       = (v_cnt >= V_W'(V_ACTIVE + V_FP)) &&
                          (v_cnt <  V_W'(V_ACTIVE + V_FP + V_SYNC));
    assign fs           = (h_cnt == '0) && (v_cnt == '0);
    assign vblank_start = (h_cnt == '0) && (v_cnt == V_W'(V_ACTIVE));

    always_ff @(posedge video_clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (fs && enable)       state_d = REQ;
            REQ:     if (rd.read_req_ack)    state_d = ARMED;
            ARMED:   if (fs)                 state_d = enable ? STREAM : IDLE;
            STREAM:  if (vblank_start)       state_d = enable ? REQ : IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    // The ARMED->STREAM edge lands one cycle after fs, so pixel 0 of the frame is read from ARMED.
    always_comb begin
        rd.read_req = 1'b0;
        req_miss    = 1'b0;
        stream_now  = 1'b0;
        unique case (state_q)
            REQ: begin
                rd.read_req = 1'b1;
                req_miss    = fs;
            end
            ARMED:   stream_now = fs && enable;
            STREAM:  stream_now = 1'b1;
            default: ;
        endcase
    end

    assign rd.read_en = stream_now && de_raw;

    always_comb begin
        raw.fs  = fs;
        raw.hs  = hs_raw;
        raw.vs  = vs_raw;
        raw.de  = de_raw;
        raw.tag = rd.read_en && !rd.read_empty;
    end

    // NOTE: the delay line is a handful of flops, not a RAM, so it is cleared on reset like any register.
    always_ff @(posedge video_clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) dly[i] <= '0;
        end else begin
            dly[0] <= raw;
            for (int i = 1; i < READ_LATENCY; i++) dly[i] <= dly[i-1];
        end
    end

    assign tap = dly[READ_LATENCY-1];

    // The tap lines up with read_data, so the final register lands READ_LATENCY+1 after raw timing.
    always_ff @(posedge video_clk) begin
        if (rst) begin
            hs          <= ~HS_ON;
            vs          <= ~VS_ON;
            de          <= 1'b0;
            vout_data   <= '0;
            frame_start <= 1'b0;
        end else begin
            hs          <= tap.hs ? HS_ON : ~HS_ON;
            vs          <= tap.vs ? VS_ON : ~VS_ON;
            de          <= tap.de;
            frame_start <= tap.fs;
            if (tap.tag)     vout_data <= rd.read_data;
            else if (tap.de) vout_data <= bg_color;
            else             vout_data <= '0;
        end
    end

    always_ff @(posedge video_clk) begin
        if (rst)                                underflow <= 1'b0;
        else if (rd.read_en && rd.read_empty)   underflow <= 1'b1;
    end

endmodule

// File: tb/tb_video_timing_reader.sv
// Random and directed bench for video_timing_reader on a 14x7 raster with a
// frame-level reference model plus hand-computed timing pins.
module tb_video_timing_reader;

    localparam int DW  = 16;
    localparam int HA  = 8;
    localparam int HFP = 2;
    localparam int HSW = 2;
    localparam int HBP = 2;
    localparam int VA  = 4;
    localparam int VFP = 1;
    localparam int VSW = 1;
    localparam int VBP = 1;
    localparam int LAT = 2;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VT  = VA + VFP + VSW + VBP;
    localparam bit HP  = 1'b1;
    localparam bit VP  = 1'b1;

    logic          video_clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [DW-1:0] bg_color;
    logic          hs;
    logic          vs;
    logic          de;
    logic [DW-1:0] vout_data;
    logic          frame_start;
    logic          underflow;
    logic          req_miss;

    video_timing_reader_if #(.DATA_WIDTH(DW)) bus ();

    video_timing_reader #(
        .DATA_WIDTH(DW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1), .VS_POL(1), .READ_LATENCY(LAT)
    ) dut (
        .video_clk  (video_clk),
        .rst        (rst),
        .enable     (enable),
        .rd         (bus),
        .bg_color   (bg_color),
        .hs         (hs),
        .vs         (vs),
        .de         (de),
        .vout_data  (vout_data),
        .frame_start(frame_start),
        .underflow  (underflow),
        .req_miss   (req_miss)
    );

    always #5 video_clk = ~video_clk;

    typedef struct packed {
        bit de;
        bit hs;
        bit vs;
        bit fs;
        bit tag;
    } raw_t;

    int      total = 0;
    int      bad   = 0;
    int      cyc   = 0;
    int      t;
    bit      model_ok = 1'b0;
    bit      m_req, m_arm, m_str;
    raw_t    pipe[$];
    bit      e_hs, e_vs, e_de, e_fs, e_uf;
    logic [DW-1:0] e_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        t     = 0;
        m_req = 1'b0;
        m_arm = 1'b0;
        m_str = 1'b0;
        pipe.delete();
        repeat (LAT) pipe.push_back('0);
        e_hs   = ~HP;
        e_vs   = ~VP;
        e_de   = 1'b0;
        e_fs   = 1'b0;
        e_uf   = 1'b0;
        e_data = '0;
    endtask

    // One clock: drive inputs after the falling edge, compare, then advance the model past the rising edge.
    task automatic step(input bit r, input bit en, input bit ak, input bit em,
                        input logic [DW-1:0] bg, input logic [DW-1:0] d);
        int   h, v;
        bit   fs, de_raw, hs_raw, vs_raw, stream_now, x_ren;
        raw_t nr, o;
        @(negedge video_clk);
        rst              = r;
        enable           = en;
        bus.read_req_ack = ak;
        bus.read_empty   = em;
        bg_color         = bg;
        bus.read_data    = d;
        #1;
        cyc++;
        h          = t % HT;
        v          = (t / HT) % VT;
        fs         = (h == 0) && (v == 0);
        de_raw     = (h < HA) && (v < VA);
        hs_raw     = (h >= HA + HFP) && (h < HA + HFP + HSW);
        vs_raw     = (v >= VA + VFP) && (v < VA + VFP + VSW);
        stream_now = m_str || (m_arm && fs && en);
        x_ren      = stream_now && de_raw;
        if (model_ok) begin
            check("hs", hs, e_hs);
            check("vs", vs, e_vs);
            check("de", de, e_de);
            check("vout_data", vout_data, e_data);
            check("frame_start", frame_start, e_fs);
            check("underflow", underflow, e_uf);
            check("read_req", bus.read_req, m_req);
            check("read_en", bus.read_en, x_ren);
            check("req_miss", req_miss, m_req && fs);
        end
        if (r) begin
            model_reset();
            model_ok = 1'b1;
        end else begin
            nr = {de_raw, hs_raw, vs_raw, fs, x_ren && !em};
            pipe.push_back(nr);
            o      = pipe.pop_front();
            e_de   = o.de;
            e_hs   = o.hs ? HP : ~HP;
            e_vs   = o.vs ? VP : ~VP;
            e_fs   = o.fs;
            e_data = o.tag ? d : (o.de ? bg : '0);
            if (x_ren && em) e_uf = 1'b1;
            // Frame-level bookkeeping: request, grant, stream a whole frame.
            if (m_req) begin
                if (ak) begin m_req = 1'b0; m_arm = 1'b1; end
            end else if (m_arm) begin
                if (fs) begin m_arm = 1'b0; m_str = en; end
            end else if (m_str) begin
                if (v == VA && h == 0) begin m_str = 1'b0; m_req = en; end
            end else if (fs && en) begin
                m_req = 1'b1;
            end
            t++;
        end
    endtask

    initial begin
        int  ren_cnt, ren_cnt2, de_cnt;
        bit  en_r, r;
        logic [DW-1:0] d;
        rst              = 1'b1;
        enable           = 1'b0;
        bg_color         = '0;
        bus.read_req_ack = 1'b0;
        bus.read_empty   = 1'b0;
        bus.read_data    = '0;
        ren_cnt  = 0;
        ren_cnt2 = 0;
        de_cnt   = 0;

        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);

        // Directed frames: k equals cycles since reset release until the mid-line reset at k=592.
        for (int k = 0; k <= 600; k++) begin
            d = 16'h1000 + 16'((k + HT - LAT) % HT);
            step(k == 592, !(k >= 300 && k < 420), (k == 1 || k == 200 || k == 495),
                 k == 115, 16'hABCD, d);
            if (k >= 98  && k < 196) ren_cnt  += int'(bus.read_en);
            if (k >= 196 && k < 294) ren_cnt2 += int'(bus.read_en);
            if (k >= 199 && k < 297) de_cnt   += int'(de);
            if (k == 0)   check("pin read_req idle", bus.read_req, 0);
            if (k == 1)   check("pin read_req rise", bus.read_req, 1);
            if (k == 2)   check("pin read_req drop", bus.read_req, 0);
            if (k == 98)  check("pin first read_en", bus.read_en, 1);
            if (k == 100) check("pin de before", de, 0);
            if (k == 101) begin
                check("pin de first", de, 1);
                check("pin pixel0", vout_data, 16'h1000);
                check("pin frame_start", frame_start, 1);
            end
            if (k == 108) check("pin pixel7", vout_data, 16'h1007);
            if (k == 110) check("pin hs before", hs, 0);
            if (k == 111) check("pin hs start", hs, 1);
            if (k == 112) check("pin hs second", hs, 1);
            if (k == 113) check("pin hs end", hs, 0);
            if (k == 115) check("pin uf clear", underflow, 0);
            if (k == 116) check("pin uf set", underflow, 1);
            if (k == 117) check("pin uf left", vout_data, 16'h1002);
            if (k == 118) check("pin uf pixel bg", vout_data, 16'hABCD);
            if (k == 119) check("pin uf right", vout_data, 16'h1004);
            if (k == 155) check("pin re-request", bus.read_req, 1);
            if (k == 196) begin
                check("pin streamed count", ren_cnt, 32);
                check("pin req_miss", req_miss, 1);
            end
            if (k == 199) check("pin miss bg", vout_data, 16'hABCD);
            if (k == 294) begin
                check("pin miss no reads", ren_cnt2, 0);
                check("pin streams after late ack", bus.read_en, 1);
            end
            if (k == 297) check("pin miss de count", de_cnt, 32);
            if (k == 300) check("pin uf sticky", underflow, 1);
            if (k == 351) check("pin disabled no req", bus.read_req, 0);
            if (k == 392) check("pin disabled no read", bus.read_en, 0);
            if (k == 395) check("pin disabled bg", vout_data, 16'hABCD);
            if (k == 491) check("pin re-enable req", bus.read_req, 1);
            if (k == 588) check("pin stream again", bus.read_en, 1);
            if (k == 593) begin
                check("pin rst hs", hs, 0);
                check("pin rst vs", vs, 0);
                check("pin rst de", de, 0);
                check("pin rst data", vout_data, 0);
                check("pin rst underflow", underflow, 0);
                check("pin rst read_en", bus.read_en, 0);
            end
            if (k == 594) check("pin idle after rst", bus.read_req, 1);
        end

        // Randomized traffic: enable toggles, sparse acks, FIFO hiccups, occasional resets.
        en_r = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) en_r = ~en_r;
            r = ($urandom_range(0, 2499) == 0);
            step(r, en_r, $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 3,
                 DW'($urandom), DW'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
